// File: rtl/stage_3_lsu.sv
// Memory-stage load/store unit: issues one req/ack data-bus access per instruction and extends load data.
// Latency: 3 cycles for an access acknowledged at once, 2 for a fault. lsu_stall holds the pipeline until DONE.
module stage_3_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] MEM_data,
  output logic        lsu_stall,
  output logic        lsu_fault,
  output logic [1:0]  lsu_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;

  logic            access;
  logic            illegal;
  logic            misaligned;
  logic [31:0]     st_data;
  logic [3:0]      st_strb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;

  // Request decode: legality, alignment and store lane placement
  always_comb begin
    access     = mem_valid & (mem_rd | mem_wr);
    illegal    = mem_rd & mem_wr;
    misaligned = 1'b0;
    if (mem_rd && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    if (mem_wr && (funct3[2] || (funct3[1:0] == 2'b11)))
      illegal = 1'b1;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_strb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        st_data = wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension, using the size/offset captured at issue
  always_comb begin
    case (ld_off)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  assign lsu_stall = (state == ST_WAIT) | ((state == ST_IDLE) & access);

  always_ff @(posedge cpu_clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ld_f3      <= 3'b000;
      ld_off     <= 2'b00;
      MEM_data   <= 32'h0;
      lsu_fault  <= 1'b0;
      lsu_cause  <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_wstrb <= 4'b0000;
    end else begin
      lsu_fault <= 1'b0;
      lsu_cause <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (illegal) begin
              lsu_fault <= 1'b1;
              lsu_cause <= 2'b11;
              state     <= ST_DONE;
            end else if (misaligned) begin
              lsu_fault <= 1'b1;
              lsu_cause <= 2'b01;
              state     <= ST_DONE;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_wr;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wdata <= mem_wr ? st_data : 32'h0;
              dmem_wstrb <= mem_wr ? st_strb : 4'b0000;
              ld_f3      <= funct3;
              ld_off     <= addr[1:0];
              cnt        <= '0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // An ack in the expiry cycle still completes the access normally
          if (dmem_ack) begin
            if (!dmem_we)
              MEM_data <= ld_ext;
            dmem_req <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            dmem_req  <= 1'b0;
            MEM_data  <= 32'h0;
            lsu_fault <= 1'b1;
            lsu_cause <= 2'b10;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_3_lsu.sv
// Randomized bench for stage_3_lsu against a transaction-level model of each access.
module tb_stage_3_lsu;
  localparam int TO = 4;

  logic        cpu_clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] MEM_data;
  logic        lsu_stall, lsu_fault;
  logic [1:0]  lsu_cause;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  stage_3_lsu #(.TIMEOUT(TO)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .funct3(funct3), .addr(addr), .wdata(wdata),
    .MEM_data(MEM_data), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault),
    .lsu_cause(lsu_cause), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations set by the driver, checked on the falling edge
  bit          chk_en = 0;
  bit          e_stall, e_req, e_fault, e_we, e_store;
  logic [1:0]  e_cause;
  logic [31:0] e_mem, e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic [31:0] mem_model = 32'h0;

  int          req_cnt = 0, stall_cnt = 0, fault_cnt = 0;
  logic [31:0] last_wdata = 32'h0, last_addr = 32'h0;
  logic [3:0]  last_strb = 4'h0;
  logic [1:0]  last_cause = 2'b00;

  always @(negedge cpu_clk) begin
    if (dmem_req) begin
      req_cnt++;
      last_wdata = dmem_wdata;
      last_addr  = dmem_addr;
      last_strb  = dmem_wstrb;
    end
    if (lsu_stall) stall_cnt++;
    if (lsu_fault) begin
      fault_cnt++;
      last_cause = lsu_cause;
    end
    if (chk_en) begin
      cmp("stall", 32'(lsu_stall), 32'(e_stall));
      cmp("req", 32'(dmem_req), 32'(e_req));
      cmp("fault", 32'(lsu_fault), 32'(e_fault));
      cmp("mem_data", MEM_data, e_mem);
      if (e_fault) cmp("cause", 32'(lsu_cause), 32'(e_cause));
      if (e_req) begin
        cmp("bus_addr", dmem_addr, e_addr);
        cmp("bus_we", 32'(dmem_we), 32'(e_we));
        cmp("bus_strb", 32'(dmem_wstrb), 32'(e_strb));
        if (e_store) cmp("bus_wdata", dmem_wdata, e_wdata);
      end
    end
  end

  // One instruction held at the inputs until its DONE cycle; d = WAIT cycle index of the ack
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input int d);
    int size, off, ncyc;
    bit ill, mis, bus, acked;
    logic [1:0] cause;
    logic [31:0] val, mask, new_mem;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(a[1:0]);
    ill   = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
    mis   = !ill && ((off % size) != 0);
    bus   = !ill && !mis;
    acked = d < TO;
    cause = ill ? 2'b11 : mis ? 2'b01 : 2'b00;
    new_mem = mem_model;
    if (bus) begin
      if (!acked) begin
        cause   = 2'b10;
        new_mem = 32'h0;
      end else if (rd) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        val  = (rdat >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        new_mem = val;
      end
    end
    ncyc    = !bus ? 2 : acked ? d + 3 : TO + 2;
    e_addr  = a & ~32'd3;
    e_we    = wr;
    e_store = wr;
    e_strb  = wr ? 4'(((1 << size) - 1) << off) : 4'b0000;
    e_wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
              (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    for (int c = 0; c < ncyc; c++) begin
      mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (bus && acked && c == d + 1) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdat;
      end else if ((c == 0 || c == ncyc - 1) && $urandom_range(3) == 0) begin
        dmem_ack = 1'b1;
      end
      e_stall = c < ncyc - 1;
      e_req   = bus && c >= 1 && c < ncyc - 1;
      e_fault = (c == ncyc - 1) && cause != 2'b00;
      e_cause = cause;
      e_mem   = (c == ncyc - 1) ? new_mem : mem_model;
      chk_en  = 1;
      @(posedge cpu_clk); #1;
    end
    chk_en = 0;
    dmem_ack = 1'b0;
    mem_model = new_mem;
  endtask

  task automatic idle_cycle();
    int k;
    k = $urandom_range(2);
    mem_valid = (k == 1); mem_rd = (k == 2); mem_wr = 1'b0;
    funct3 = 3'($urandom_range(7)); addr = $urandom; wdata = $urandom;
    dmem_ack = 1'($urandom_range(1)); dmem_rdata = $urandom;
    e_stall = 0; e_req = 0; e_fault = 0; e_mem = mem_model;
    chk_en = 1;
    @(posedge cpu_clk); #1;
    chk_en = 0;
    dmem_ack = 1'b0;
  endtask

  bit          r_rd, r_wr;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_wd, r_dat;
  int          r_sel, r_d;

  initial begin
    repeat (2) @(posedge cpu_clk);
    #1;
    cmp("rst_mem_data", MEM_data, 32'h0);
    cmp("rst_req", 32'(dmem_req), 32'h0);
    cmp("rst_we", 32'(dmem_we), 32'h0);
    cmp("rst_addr", dmem_addr, 32'h0);
    cmp("rst_wdata", dmem_wdata, 32'h0);
    cmp("rst_wstrb", 32'(dmem_wstrb), 32'h0);
    cmp("rst_fault", 32'(lsu_fault), 32'h0);
    cmp("rst_cause", 32'(lsu_cause), 32'h0);
    cmp("rst_stall", 32'(lsu_stall), 32'h0);
    reset = 1'b1;
    mem_model = 32'h0;
    idle_cycle();

    req_cnt = 0; stall_cnt = 0;
    run_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 0);
    cmp("lw_data", MEM_data, 32'h1234_5678);
    cmp("lw_req_cycles", 32'(req_cnt), 32'd1);
    cmp("lw_stall_cycles", 32'(stall_cnt), 32'd2);
    cmp("lw_bus_addr", last_addr, 32'h100);
    cmp("lw_bus_strb", 32'(last_strb), 32'h0);

    stall_cnt = 0;
    run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0011, 2);
    cmp("lb_data", MEM_data, 32'hFFFF_FF80);
    cmp("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    run_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0011, 2);
    cmp("lbu_data", MEM_data, 32'h0000_0080);

    run_txn(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    cmp("sh_wdata", last_wdata, 32'hABCD_ABCD);
    cmp("sh_strb", 32'(last_strb), 32'hC);
    cmp("sh_mem_kept", MEM_data, 32'h0000_0080);

    req_cnt = 0;
    run_txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    cmp("mis_cause", 32'(last_cause), 32'd1);
    cmp("mis_no_req", 32'(req_cnt), 32'd0);
    run_txn(0, 1, 3'b100, 32'h200, 32'h1, 32'h0, 0);
    cmp("ill_cause", 32'(last_cause), 32'd3);

    req_cnt = 0;
    run_txn(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, TO);
    cmp("to_req_cycles", 32'(req_cnt), 32'(TO));
    cmp("to_cause", 32'(last_cause), 32'd2);
    cmp("to_data", MEM_data, 32'h0);
    req_cnt = 0; fault_cnt = 0;
    run_txn(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFE_F00D, TO - 1);
    cmp("late_ack_data", MEM_data, 32'hCAFE_F00D);
    cmp("late_ack_req_cycles", 32'(req_cnt), 32'(TO));
    cmp("late_ack_no_fault", 32'(fault_cnt), 32'd0);

    // Reset while an access is outstanding, then a stray ack
    mem_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h200;
    @(posedge cpu_clk); #1;
    cmp("mid_req_up", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    @(posedge cpu_clk); #1;
    mem_valid = 1'b0;
    #1;
    cmp("mid_rst_req", 32'(dmem_req), 32'h0);
    cmp("mid_rst_mem", MEM_data, 32'h0);
    cmp("mid_rst_addr", dmem_addr, 32'h0);
    cmp("mid_rst_wstrb", 32'(dmem_wstrb), 32'h0);
    cmp("mid_rst_fault", 32'(lsu_fault), 32'h0);
    cmp("mid_rst_stall", 32'(lsu_stall), 32'h0);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55AA_55AA;
    @(posedge cpu_clk); #1;
    dmem_ack = 1'b0;
    cmp("stray_ack_req", 32'(dmem_req), 32'h0);
    cmp("stray_ack_mem", MEM_data, 32'h0);
    cmp("stray_ack_fault", 32'(lsu_fault), 32'h0);
    mem_model = 32'h0;

    for (int i = 0; i < 400; i++) begin
      r_sel = $urandom_range(9);
      r_rd = (r_sel < 5) || (r_sel == 9);
      r_wr = (r_sel >= 5);
      if ($urandom_range(3) != 0) begin
        if (r_rd) begin
          case ($urandom_range(4))
            0: r_f3 = 3'b000;
            1: r_f3 = 3'b001;
            2: r_f3 = 3'b010;
            3: r_f3 = 3'b100;
            default: r_f3 = 3'b101;
          endcase
        end else begin
          r_f3 = 3'($urandom_range(2));
        end
      end else begin
        r_f3 = 3'($urandom_range(7));
      end
      r_a = $urandom;
      if ($urandom_range(1) == 1) r_a[1:0] = 2'b00;
      r_wd = $urandom;
      r_dat = $urandom;
      r_d = $urandom_range(TO + 1);
      run_txn(r_rd, r_wr, r_f3, r_a, r_wd, r_dat, r_d);
      if ($urandom_range(1) == 1) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
